mod_sha2_compressor: RTL and testbench

MOD_SHA2_COMPRESSOR -- requirements
Module: mod_sha2_compressor

---
 rtl/mod_sha2_compressor.sv | 147 ++++++++++++++
 tb/tb_mod_sha2_compressor.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sha2_compressor.sv
// SHA-2 compression core: one round per clock, with K/W supplied externally for ROUND_IDX.
// WORD_W=32 selects SHA-256 (64 rounds), WORD_W=64 selects SHA-512 (80 rounds).
module mod_sha2_compressor #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic                CHAIN,
  input  logic [8*WORD_W-1:0] H_IN,
  input  logic [WORD_W-1:0]   K_IN,
  input  logic [WORD_W-1:0]   W_IN,
  output logic [6:0]          ROUND_IDX,
  output logic                BUSY,
  output logic                DONE,
  output logic [8*WORD_W-1:0] DIGEST
);

  generate
    if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
      $error("mod_sha2_compressor: WORD_W/ROUNDS must be 32/64 or 64/80");
    end
  endgenerate

  localparam int S0_R1 = (WORD_W == 32) ? 2  : 28;
  localparam int S0_R2 = (WORD_W == 32) ? 13 : 34;
  localparam int S0_R3 = (WORD_W == 32) ? 22 : 39;
  localparam int S1_R1 = (WORD_W == 32) ? 6  : 14;
  localparam int S1_R2 = (WORD_W == 32) ? 11 : 18;
  localparam int S1_R3 = (WORD_W == 32) ? 25 : 41;
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [8*WORD_W-1:0] digest_q, digest_d;
  logic [WORD_W-1:0]   work_q [8];
  logic [WORD_W-1:0]   work_d [8];
  logic [WORD_W-1:0]   chain_q [8];
  logic [WORD_W-1:0]   chain_d [8];

  logic [WORD_W-1:0]   h_in_w [8];
  logic [WORD_W-1:0]   digest_w [8];
  logic [8*WORD_W-1:0] final_sum;
  logic [WORD_W-1:0]   sig0, sig1, ch, maj, t1, t2;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    rotr = (x >> n) | (x << (WORD_W - n));
  endfunction

  // Word 0 (H0 / a) lives in the most significant slice of the packed buses.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_words
      assign h_in_w[gi]   = H_IN[(8-gi)*WORD_W-1 -: WORD_W];
      assign digest_w[gi] = digest_q[(8-gi)*WORD_W-1 -: WORD_W];
      assign final_sum[(8-gi)*WORD_W-1 -: WORD_W] = chain_q[gi] + work_q[gi];
    end
  endgenerate

  always_comb begin
    sig0 = rotr(work_q[0], S0_R1) ^ rotr(work_q[0], S0_R2) ^ rotr(work_q[0], S0_R3);
    sig1 = rotr(work_q[4], S1_R1) ^ rotr(work_q[4], S1_R2) ^ rotr(work_q[4], S1_R3);
    ch   = (work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]);
    maj  = (work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]);
    t1   = work_q[7] + sig1 + ch + K_IN + W_IN;
    t2   = sig0 + maj;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    digest_d = digest_q;
    work_d   = work_q;
    chain_d  = chain_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          for (int i = 0; i < 8; i++) begin
            chain_d[i] = CHAIN ? digest_w[i] : h_in_w[i];
            work_d[i]  = chain_d[i];
          end
          cnt_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        work_d[0] = t1 + t2;
        work_d[1] = work_q[0];
        work_d[2] = work_q[1];
        work_d[3] = work_q[2];
        work_d[4] = work_q[3] + t1;
        work_d[5] = work_q[4];
        work_d[6] = work_q[5];
        work_d[7] = work_q[6];
        if (cnt_q == LAST_ROUND) begin
          cnt_d   = '0;
          state_d = S_FINAL;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_FINAL: begin
        digest_d = final_sum;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      digest_q <= '0;
      for (int i = 0; i < 8; i++) begin
        work_q[i]  <= '0;
        chain_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      digest_q <= digest_d;
      for (int i = 0; i < 8; i++) begin
        work_q[i]  <= work_d[i];
        chain_q[i] <= chain_d[i];
      end
    end
  end

  assign ROUND_IDX = (state_q == S_ROUND) ? cnt_q : 7'd0;
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign DIGEST    = digest_q;

endmodule

// File: tb/tb_mod_sha2_compressor.sv
// Self-checking bench: SHA-256 and SHA-512 instances checked against known answers and a
// word-level software model of the FIPS 180-4 compression function.
`timescale 1ns/1ps
module tb_mod_sha2_compressor;
  typedef logic [63:0] u64;
  typedef u64 w8_t [8];
  typedef u64 w16_t [16];
  typedef u64 w80_t [80];

  typedef struct {
    string        name;
    bit           sel;
    bit           chain;
    bit           b2b;
    logic [511:0] hin;
    w16_t         blk;
    logic [511:0] exp;
    bit           known;
  } vec_t;

  localparam u64 K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };
  // SHA-256 constants and IV are the upper halves of the SHA-512 ones.
  localparam u64 IV512 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam logic [255:0] ABC256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO256 =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] ABC512 = {64'hddaf35a193617aba, 64'hcc417349ae204131,
    64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a, 64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
    64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         rst32, start32, chain32, busy32, done32;
  logic [255:0] hin32, dig32;
  logic [31:0]  k32, w32;
  logic [6:0]   ridx32;
  logic         rst64, start64, chain64, busy64, done64;
  logic [511:0] hin64, dig64;
  logic [63:0]  k64, w64;
  logic [6:0]   ridx64;
  u64           sched32 [80];
  u64           sched64 [80];

  assign k32 = 32'(K512[ridx32] >> 32);
  assign w32 = 32'(sched32[ridx32]);
  assign k64 = K512[ridx64];
  assign w64 = sched64[ridx64];

  mod_sha2_compressor #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .CLK(CLK), .RESET(rst32), .START(start32), .CHAIN(chain32), .H_IN(hin32),
    .K_IN(k32), .W_IN(w32), .ROUND_IDX(ridx32), .BUSY(busy32), .DONE(done32), .DIGEST(dig32));

  mod_sha2_compressor #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .CLK(CLK), .RESET(rst64), .START(start64), .CHAIN(chain64), .H_IN(hin64),
    .K_IN(k64), .W_IN(w64), .ROUND_IDX(ridx64), .BUSY(busy64), .DONE(done64), .DIGEST(dig64));

  int n_cmp = 0;
  int n_bad = 0;
  logic [511:0] exp_dig [2];

  // ---------------- reference model ----------------
  function automatic u64 msk(input int w);
    return (w == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic u64 rotr(input u64 x, input int n, input int w);
    return ((x >> n) | (x << (w - n))) & msk(w);
  endfunction

  function automatic void expand(input int w, input w16_t blk, output w80_t ws);
    u64 s0, s1;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        ws[t] = blk[t] & msk(w);
      end else begin
        if (w == 32) begin
          s0 = rotr(ws[t-15], 7, 32) ^ rotr(ws[t-15], 18, 32) ^ (ws[t-15] >> 3);
          s1 = rotr(ws[t-2], 17, 32) ^ rotr(ws[t-2], 19, 32) ^ (ws[t-2] >> 10);
        end else begin
          s0 = rotr(ws[t-15], 1, 64) ^ rotr(ws[t-15], 8, 64) ^ (ws[t-15] >> 7);
          s1 = rotr(ws[t-2], 19, 64) ^ rotr(ws[t-2], 61, 64) ^ (ws[t-2] >> 6);
        end
        ws[t] = (s1 + ws[t-7] + s0 + ws[t-16]) & msk(w);
      end
    end
  endfunction

  function automatic void compress(input int w, input w8_t hv, input w16_t blk, output w8_t ho);
    w80_t ws;
    u64 v [8];
    u64 m, k, t1, t2, s0, s1, ch, mj;
    m = msk(w);
    expand(w, blk, ws);
    for (int i = 0; i < 8; i++) v[i] = hv[i];
    for (int t = 0; t < ((w == 32) ? 64 : 80); t++) begin
      k = (w == 32) ? (K512[t] >> 32) : K512[t];
      if (w == 32) begin
        s1 = rotr(v[4], 6, 32) ^ rotr(v[4], 11, 32) ^ rotr(v[4], 25, 32);
        s0 = rotr(v[0], 2, 32) ^ rotr(v[0], 13, 32) ^ rotr(v[0], 22, 32);
      end else begin
        s1 = rotr(v[4], 14, 64) ^ rotr(v[4], 18, 64) ^ rotr(v[4], 41, 64);
        s0 = rotr(v[0], 28, 64) ^ rotr(v[0], 34, 64) ^ rotr(v[0], 39, 64);
      end
      ch = ((v[4] & v[5]) ^ (~v[4] & v[6])) & m;
      mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t1 = (v[7] + s1 + ch + k + ws[t]) & m;
      t2 = (s0 + mj) & m;
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = (v[3] + t1) & m;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = (t1 + t2) & m;
    end
    for (int i = 0; i < 8; i++) ho[i] = (hv[i] + v[i]) & m;
  endfunction

  function automatic logic [511:0] pack8(input int w, input w8_t x);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (w == 32) r[255-32*i -: 32] = x[i][31:0];
      else         r[511-64*i -: 64] = x[i];
    end
    return r;
  endfunction

  function automatic w8_t unpack8(input int w, input logic [511:0] v);
    w8_t x;
    for (int i = 0; i < 8; i++)
      x[i] = (w == 32) ? {32'd0, v[255-32*i -: 32]} : v[511-64*i -: 64];
    return x;
  endfunction

  function automatic logic [511:0] model(input bit sel, input bit chain, input logic [511:0] hin,
                                         input w16_t blk, input logic [511:0] prev);
    int w;
    w8_t ho;
    w = sel ? 64 : 32;
    compress(w, unpack8(w, chain ? prev : hin), blk, ho);
    return pack8(w, ho);
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic w16_t rand_blk(input bit sel);
    w16_t b;
    for (int i = 0; i < 16; i++) b[i] = sel ? {$urandom, $urandom} : {32'd0, $urandom};
    return b;
  endfunction

  function automatic logic cur_done(input bit sel); return sel ? done64 : done32; endfunction
  function automatic logic cur_busy(input bit sel); return sel ? busy64 : busy32; endfunction
  function automatic logic [6:0] cur_ridx(input bit sel); return sel ? ridx64 : ridx32; endfunction
  function automatic logic [511:0] cur_dig(input bit sel);
    return sel ? dig64 : {256'd0, dig32};
  endfunction

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit s, input bit c, input logic [511:0] h);
    if (sel) begin start64 = s; chain64 = c; hin64 = h; end
    else     begin start32 = s; chain32 = c; hin32 = h[255:0]; end
  endtask

  // Called at a negedge; the following rising edge samples START.
  task automatic launch(input bit sel, input bit chain, input logic [511:0] hin, input w16_t blk);
    w80_t ws;
    expand(sel ? 64 : 32, blk, ws);
    for (int t = 0; t < 80; t++) begin
      if (sel) sched64[t] = ws[t];
      else     sched32[t] = ws[t];
    end
    drive(sel, 1'b1, chain, hin);
    @(negedge CLK);
    drive(sel, 1'b0, 1'($urandom), rand512());
  endtask

  // Returns at the negedge where DONE is seen; e counts edges after the accepting edge.
  task automatic wait_done(input string name, input bit sel, input int inject, input logic [511:0] hold);
    int e, rounds, ridx_bad, busy_bad, hold_bad;
    bit seen;
    rounds = sel ? 80 : 64;
    e = 0; seen = 0; ridx_bad = 0; busy_bad = 0; hold_bad = 0;
    while (e < 400 && !seen) begin
      if (cur_done(sel)) begin
        seen = 1;
      end else begin
        if (cur_ridx(sel) !== ((e < rounds) ? 7'(e) : 7'd0)) ridx_bad++;
        if (cur_busy(sel) !== 1'b1) busy_bad++;
        if (cur_dig(sel) !== hold) hold_bad++;
        drive(sel, e == inject, 1'($urandom), rand512());
        @(negedge CLK);
        e++;
      end
    end
    check({name, "_latency"}, 512'(e), 512'(rounds + 1));
    check({name, "_busy_done"}, 512'(cur_busy(sel)), 512'(0));
    check({name, "_ridx_seq"}, 512'(ridx_bad), 512'(0));
    check({name, "_busy_seq"}, 512'(busy_bad), 512'(0));
    check({name, "_digest_hold"}, 512'(hold_bad), 512'(0));
  endtask

  task automatic run_block(input string name, input bit sel, input bit chain, input bit b2b,
                           input logic [511:0] hin, input w16_t blk, input logic [511:0] exp,
                           input int inject);
    if (!b2b) begin
      @(negedge CLK);
      check({name, "_done_low"}, 512'(cur_done(sel)), 512'(0));
      @(negedge CLK);
    end
    launch(sel, chain, hin, blk);
    wait_done(name, sel, inject, exp_dig[sel]);
    check({name, "_digest"}, cur_dig(sel), exp);
    $display("txn %s: dw=%0d chain=%0d digest=%0h", name, sel ? 64 : 32, chain, cur_dig(sel));
    exp_dig[sel] = exp;
  endtask

  task automatic watch_idle(input string name, input bit sel, input int n);
    int pulses, busy_hi;
    pulses = 0; busy_hi = 0;
    repeat (n) begin
      @(negedge CLK);
      if (cur_done(sel)) pulses++;
      if (cur_busy(sel)) busy_hi++;
    end
    check({name, "_extra_done"}, 512'(pulses), 512'(0));
    check({name, "_extra_busy"}, 512'(busy_hi), 512'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    w16_t abc32, abc64, two1, two2, rb;
    w8_t iv_w;
    logic [511:0] iv256, iv512, expv, prev [2];
    vec_t tbl [5];
    bit sel, ch, bb;
    int e;

    abc32 = '{default: 64'd0}; abc64 = '{default: 64'd0};
    two1 = '{default: 64'd0};  two2 = '{default: 64'd0};
    abc32[0] = 64'h61626380; abc32[15] = 64'h18;
    abc64[0] = 64'h6162638000000000; abc64[15] = 64'h18;
    two1[0] = 64'h61626364; two1[1] = 64'h62636465; two1[2] = 64'h63646566; two1[3] = 64'h64656667;
    two1[4] = 64'h65666768; two1[5] = 64'h66676869; two1[6] = 64'h6768696a; two1[7] = 64'h68696a6b;
    two1[8] = 64'h696a6b6c; two1[9] = 64'h6a6b6c6d; two1[10] = 64'h6b6c6d6e; two1[11] = 64'h6c6d6e6f;
    two1[12] = 64'h6d6e6f70; two1[13] = 64'h6e6f7071; two1[14] = 64'h80000000;
    two2[15] = 64'h1c0;
    for (int i = 0; i < 8; i++) iv_w[i] = IV512[i] >> 32;
    iv256 = pack8(32, iv_w);
    for (int i = 0; i < 8; i++) iv_w[i] = IV512[i];
    iv512 = pack8(64, iv_w);
    exp_dig[0] = '0; exp_dig[1] = '0;
    for (int t = 0; t < 80; t++) begin sched32[t] = '0; sched64[t] = '0; end

    // Reset holds the FSM idle even with START asserted.
    rst32 = 1'b1; rst64 = 1'b1;
    drive(0, 1'b1, 1'b1, rand512());
    drive(1, 1'b1, 1'b1, rand512());
    repeat (3) @(negedge CLK);
    for (int s = 0; s < 2; s++) begin
      check("rst_busy", 512'(cur_busy(1'(s))), 512'(0));
      check("rst_done", 512'(cur_done(1'(s))), 512'(0));
      check("rst_ridx", 512'(cur_ridx(1'(s))), 512'(0));
      check("rst_digest", cur_dig(1'(s)), 512'(0));
    end

    // First START on the edge right after reset release, chaining from the zero digest.
    rst32 = 1'b0; rst64 = 1'b0;
    drive(1, 1'b0, 1'b0, '0);
    expv = model(0, 1'b1, iv256, abc32, '0);
    launch(0, 1'b1, iv256, abc32);
    wait_done("chain_after_rst", 0, -1, '0);
    check("chain_after_rst_digest", cur_dig(0), expv);
    exp_dig[0] = expv;

    tbl[0] = '{"abc256",        0, 0, 0, iv256,     abc32, {256'd0, ABC256}, 1};
    tbl[1] = '{"twoblk_1",      0, 0, 0, iv256,     two1,  '0,               0};
    tbl[2] = '{"twoblk_2",      0, 1, 1, rand512(), two2,  {256'd0, TWO256}, 1};
    tbl[3] = '{"abc512",        1, 0, 0, iv512,     abc64, ABC512,           1};
    tbl[4] = '{"abc512_chain",  1, 1, 1, rand512(), abc64, '0,               0};
    prev[0] = exp_dig[0]; prev[1] = exp_dig[1];
    for (int i = 0; i < 5; i++) begin
      if (!tbl[i].known)
        tbl[i].exp = model(tbl[i].sel, tbl[i].chain, tbl[i].hin, tbl[i].blk, prev[tbl[i].sel]);
      prev[tbl[i].sel] = tbl[i].exp;
    end
    for (int i = 0; i < 5; i++)
      run_block(tbl[i].name, tbl[i].sel, tbl[i].chain, tbl[i].b2b, tbl[i].hin, tbl[i].blk,
                tbl[i].exp, -1);

    for (int r = 0; r < 7; r++) begin
      sel = (r >= 5);
      ch  = 1'($urandom);
      bb  = 1'($urandom);
      expv = rand512();
      rb  = rand_blk(sel);
      run_block($sformatf("rand%0d", r), sel, ch, bb, expv, rb,
                model(sel, ch, expv, rb, exp_dig[sel]), -1);
    end

    // START pulsed mid-block must be ignored.
    run_block("abc256_start_mid", 0, 0, 0, iv256, abc32, {256'd0, ABC256}, 10);
    watch_idle("abc256_start_mid", 0, 90);

    // Reset at round 30 aborts the block without DONE.
    @(negedge CLK);
    launch(0, 1'b0, iv256, abc32);
    e = 0;
    while (ridx32 != 7'd30 && e < 100) begin @(negedge CLK); e++; end
    check("rst_mid_reach30", 512'(ridx32), 512'(30));
    rst32 = 1'b1;
    @(negedge CLK);
    rst32 = 1'b0;
    check("rst_mid_busy", 512'(busy32), 512'(0));
    check("rst_mid_done", 512'(done32), 512'(0));
    check("rst_mid_digest", {256'd0, dig32}, 512'(0));
    watch_idle("rst_mid", 0, 80);
    exp_dig[0] = '0;
    run_block("abc256_after_rst", 0, 0, 0, iv256, abc32, {256'd0, ABC256}, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
